// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  localparam int unsigned DefTimeoutCycles = 255;

  // Index width that stays legal for a single-entry array.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Host, device and address-map signals of the arbiter; slave is the arbiter view.
interface bus_rr_arbiter_if #(
  parameter int unsigned NrHosts      = 3,
  parameter int unsigned NrDevices    = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);

  logic                      host_req_i    [NrHosts];
  logic                      host_gnt_o    [NrHosts];
  logic [AddressWidth-1:0]   host_addr_i   [NrHosts];
  logic                      host_we_i     [NrHosts];
  logic [DataWidth/8-1:0]    host_be_i     [NrHosts];
  logic [DataWidth-1:0]      host_wdata_i  [NrHosts];
  logic                      host_rvalid_o [NrHosts];
  logic [DataWidth-1:0]      host_rdata_o  [NrHosts];
  logic                      host_err_o    [NrHosts];

  logic                      device_req_o    [NrDevices];
  logic [AddressWidth-1:0]   device_addr_o   [NrDevices];
  logic                      device_we_o     [NrDevices];
  logic [DataWidth/8-1:0]    device_be_o     [NrDevices];
  logic [DataWidth-1:0]      device_wdata_o  [NrDevices];
  logic                      device_rvalid_i [NrDevices];
  logic [DataWidth-1:0]      device_rdata_i  [NrDevices];
  logic                      device_err_i    [NrDevices];

  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices];
  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices];

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo N.
module bus_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] winner_o
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last_i) + k;
      if (idx >= N) idx = idx - N;
      if (!valid_o && req_i[IW'(idx)]) begin
        valid_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Multi-host to multi-device bus arbiter: round-robin grant, address decode,
// one outstanding transfer with response pass-through, decode error and timeout.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts       = 3,
  parameter int unsigned NrDevices     = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  bus_rr_arbiter_if.slave bus
);

  localparam int unsigned HIW = idx_w(NrHosts);
  localparam int unsigned DIW = idx_w(NrDevices);
  localparam int unsigned TCW = $clog2(TimeoutCycles + 1);
  localparam int unsigned BW  = DataWidth / 8;

  arb_state_e r_state, w_state_d;
  logic [HIW-1:0] r_last_grant, r_host;
  logic [DIW-1:0] r_dev;
  logic           r_dec_err;
  logic [TCW-1:0] r_tcnt;

  logic [NrHosts-1:0]      w_req;
  logic                    w_pick_vld;
  logic [HIW-1:0]          w_winner;
  logic [AddressWidth-1:0] w_addr;
  logic                    w_we;
  logic [BW-1:0]           w_be;
  logic [DataWidth-1:0]    w_wdata;
  logic                    w_dec_hit;
  logic [DIW-1:0]          w_dec_dev;
  logic                    w_dev_rvalid, w_dev_err, w_timeout;
  logic [DataWidth-1:0]    w_dev_rdata;

  always_comb begin
    w_req = '0;
    for (int h = 0; h < int'(NrHosts); h++) w_req[h] = bus.host_req_i[h];
  end

  bus_rr_pick #(.N(NrHosts)) u_pick (
    .req_i    (w_req),
    .last_i   (r_last_grant),
    .valid_o  (w_pick_vld),
    .winner_o (w_winner)
  );

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_wdata = '0;
    for (int h = 0; h < int'(NrHosts); h++) begin
      if (w_winner == HIW'(h)) begin
        w_addr  = bus.host_addr_i[h];
        w_we    = bus.host_we_i[h];
        w_be    = bus.host_be_i[h];
        w_wdata = bus.host_wdata_i[h];
      end
    end
  end

  // First match in ascending order gives the lowest index priority on overlap.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_dev = '0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (!w_dec_hit &&
          ((w_addr & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d])) begin
        w_dec_hit = 1'b1;
        w_dec_dev = DIW'(d);
      end
    end
  end

  always_comb begin
    w_dev_rvalid = 1'b0;
    w_dev_rdata  = '0;
    w_dev_err    = 1'b0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (r_dev == DIW'(d)) begin
        w_dev_rvalid = bus.device_rvalid_i[d];
        w_dev_rdata  = bus.device_rdata_i[d];
        w_dev_err    = bus.device_err_i[d];
      end
    end
  end

  // r_tcnt is 0 in the first RESP cycle, so expiry lands TimeoutCycles after the grant.
  assign w_timeout = (r_state == ST_RESP) && !r_dec_err && !w_dev_rvalid &&
                     (r_tcnt == TCW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_d = ST_RESP;
      ST_RESP: if (r_dec_err || w_dev_rvalid || w_timeout) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_grant <= HIW'(NrHosts - 1);
      r_host       <= '0;
      r_dev        <= '0;
      r_dec_err    <= 1'b0;
      r_tcnt       <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tcnt <= '0;
      if (w_pick_vld) begin
        r_last_grant <= w_winner;
        r_host       <= w_winner;
        r_dev        <= w_dec_dev;
        r_dec_err    <= !w_dec_hit;
      end
    end else begin
      r_tcnt <= r_tcnt + TCW'(1);
    end
  end

  // Outputs are gated by reset so nothing leaks while rst_ni is low.
  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      bus.host_gnt_o[h]    = 1'b0;
      bus.host_rvalid_o[h] = 1'b0;
      bus.host_rdata_o[h]  = '0;
      bus.host_err_o[h]    = 1'b0;
    end
    for (int d = 0; d < int'(NrDevices); d++) begin
      bus.device_req_o[d]   = 1'b0;
      bus.device_addr_o[d]  = '0;
      bus.device_we_o[d]    = 1'b0;
      bus.device_be_o[d]    = '0;
      bus.device_wdata_o[d] = '0;
    end
    if (rst_ni) begin
      if (r_state == ST_IDLE && w_pick_vld) begin
        for (int h = 0; h < int'(NrHosts); h++)
          if (w_winner == HIW'(h)) bus.host_gnt_o[h] = 1'b1;
        for (int d = 0; d < int'(NrDevices); d++) begin
          if (w_dec_hit && w_dec_dev == DIW'(d)) begin
            bus.device_req_o[d]   = 1'b1;
            bus.device_addr_o[d]  = w_addr;
            bus.device_we_o[d]    = w_we;
            bus.device_be_o[d]    = w_be;
            bus.device_wdata_o[d] = w_wdata;
          end
        end
      end else if (r_state == ST_RESP) begin
        for (int h = 0; h < int'(NrHosts); h++) begin
          if (r_host == HIW'(h)) begin
            if (r_dec_err || w_timeout) begin
              bus.host_rvalid_o[h] = 1'b1;
              bus.host_err_o[h]    = 1'b1;
            end else if (w_dev_rvalid) begin
              bus.host_rvalid_o[h] = 1'b1;
              bus.host_rdata_o[h]  = w_dev_rdata;
              bus.host_err_o[h]    = w_dev_err;
            end
          end
        end
      end
    end
  end

endmodule
